des_key_sequencer: RTL and testbench
====================================

# des_key_sequencer

Upstream feeder for the DES round-key generator in the 3DES datapath. Accepts a 192-bit key bundle (K1,K2,K3) and a direction, applies PC-1 (parity drop plus permutation) to each key, and presents one 56-bit key and per-stage direction at a time for consumption by the round-key generator and DES core. It sequences the three DES stages in EDE order (or one stage in single-DES mode) under a stage-done handshake from the core.

## Interface
- No parameters; all widths fixed by the DES standard.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- key_in  in  [0:191]  {K1,K2,K3}, each [0:63]; bit 0 = DES bit 1 (MSB-first)
- mode_3des  in  1  1 = three-stage 3DES, 0 = single DES using K1 only
- encrypt_in  in  1  1 = encrypt sequence, 0 = decrypt sequence
- load_valid  in  1  key bundle, mode and direction valid this cycle
- load_ready  out  1  sequencer idle; load accepted when load_valid & load_ready
- stage_key  out  [0:55]  PC-1 output for current stage; C = [0:27], D = [28:55]
- stage_is_encrypt  out  1  direction for current stage, drives round-key generator
- stage_index  out  2  current stage, 0..2
- stage_valid  out  1  stage_key/stage_is_encrypt/stage_index are valid
- stage_done  in  1  one-cycle pulse from DES core: current stage's 16 rounds complete
- seq_done  out  1  one-cycle pulse: final stage consumed
- parity_err  out  1  a used key failed DES odd byte parity; holds until next accepted load

## Operation
- PC-1: stage_key[j] = K[PC1[j]-1]; PC1 = 57 49 41 33 25 17 9 1 58 50 42 34 26 18 10 2 59 51 43 35 27 19 11 3 60 52 44 36 | 63 55 47 39 31 23 15 7 62 54 46 38 30 22 14 6 61 53 45 37 29 21 13 5 28 20 12 4.
- On accept, all three 56-bit PC-1 results, mode and direction are registered; key_in is not sampled afterwards.
- Stage order:
  - 3DES encrypt: (K1,E), (K2,D), (K3,E).
  - 3DES decrypt: (K3,D), (K2,E), (K1,D).
  - Single DES: (K1, encrypt_in).
- FSM: IDLE -> ACTIVE on accept; ACTIVE advances on stage_done; after the last stage it returns to IDLE.
- IDLE: load_ready=1, stage_valid=0.
- ACTIVE: load_ready=0, stage_valid=1.
- Parity: each byte of each used key must contain an odd number of ones. Only K1 is checked in single mode. Result is registered at accept. It is a flag only and never blocks sequencing.
- Ignored inputs: stage_done while stage_valid=0; load_valid while load_ready=0.
- Bundle with K1=K2=K3 is legal; no special handling.

## Timing
- Reset values: load_ready=1, stage_valid=0, stage_key=0, stage_is_encrypt=0, stage_index=0, seq_done=0, parity_err=0; FSM in IDLE.
- All outputs are registered.
- Accept at edge N: stage_valid=1 and stage 0 outputs present from cycle N+1. load_ready=0 from N+1.
- stage_done at edge M, not last stage: stage_index, stage_key and stage_is_encrypt update at M+1. stage_valid stays 1, so there is no bubble.
- stage_done at edge M, last stage: at M+1, stage_valid=0, seq_done=1 for exactly one cycle, and load_ready=1.
- A load accepted in the seq_done cycle is legal; stage_valid rises on the following cycle.
- Stage outputs are stable for the whole time stage_valid=1 and change only on stage_done.
- stage_key returns to 0 when leaving ACTIVE.
- rst asserted at any cycle, including mid-sequence or coincident with stage_done or load_valid, wins. All reset values apply at the next edge, and any in-flight sequence is discarded.
- Minimum sequence length: 3 cycles (3DES) or 1 cycle (single), when stage_done is pulsed every cycle.

## Test plan
- Reset, then single-DES encrypt with K1=0x133457799BBCDFF1:
  - stage_key=0xF0CCAAF556678F and stage_is_encrypt=1 one cycle after accept.
  - stage_done -> seq_done pulse with parity_err=0.
- 3DES encrypt with K1=0x133457799BBCDFF1, K2=0x0101010101010101, K3=0xFEFEFEFEFEFEFEFE:
  - Stages are (0xF0CCAAF556678F,E), (0x00000000000000,D), (0xFFFFFFFFFFFFFF,E) with stage_index 0,1,2.
  - parity_err=0.
- Same bundle, 3DES decrypt: stages are (0xFFFFFFFFFFFFFF,D), (0x0,E), (0xF0CCAAF556678F,D).
- Handshake edges:
  - load_valid held during ACTIVE is ignored and load_ready stays 0.
  - stage_done in IDLE is ignored.
  - stage_done on consecutive cycles gives 3 back-to-back stages then seq_done.
  - A new load accepted in the seq_done cycle starts a new sequence.
- Parity:
  - K2=0x0000000000000000 in 3DES gives parity_err=1, and the sequence still completes.
  - The same K2 with mode_3des=0 gives parity_err=0, since K2 is unused.
- rst pulsed while stage_index=1: next cycle shows all reset values. A subsequent load restarts at stage 0.

Source files
------------

// File: rtl/des_key_sequencer.sv
// des_key_sequencer
//   Front end of the 3DES datapath. Accepts a {K1,K2,K3} key bundle with
//   mode and direction, reduces each key through PC-1, and presents one
//   56-bit key plus its direction per DES stage to the round-key generator.
//   Stages run in EDE order (3DES) or as a single K1 stage (single DES),
//   advancing on stage_done pulses from the DES core.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   key_in[0:191]     {K1,K2,K3}, index 0 = DES bit 1
//   mode_3des         1 = three stages, 0 = single DES on K1
//   encrypt_in        requested direction
//   load_valid/ready  bundle handshake; ready only while idle
//   stage_key[0:55]   PC-1 result for current stage (C = [0:27], D = [28:55])
//   stage_is_encrypt  direction of current stage
//   stage_index       current stage 0..2
//   stage_valid       stage outputs valid
//   stage_done        core pulse: current stage finished
//   seq_done          one-cycle pulse after the final stage
//   parity_err        odd-parity failure on a used key, held until next load
module des_key_sequencer (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:191] key_in,
    input  logic         mode_3des,
    input  logic         encrypt_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic [0:55]  stage_key,
    output logic         stage_is_encrypt,
    output logic [1:0]   stage_index,
    output logic         stage_valid,
    input  logic         stage_done,
    output logic         seq_done,
    output logic         parity_err
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // PC-1 source positions, stored zero-based (standard table minus one).
    localparam logic [5:0] PC1_IDX [56] = '{
        6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,  6'd0,
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
        6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
        6'd59, 6'd51, 6'd43, 6'd35,
        6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6,
        6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,
        6'd60, 6'd52, 6'd44, 6'd36, 6'd28, 6'd20, 6'd12, 6'd4,
        6'd27, 6'd19, 6'd11, 6'd3
    };

    function automatic logic [0:55] pc1(input logic [0:63] k);
        logic [0:55] r;
        r = '0;
        for (int unsigned j = 0; j < 56; j++) begin
            r[j[5:0]] = k[PC1_IDX[j[5:0]]];
        end
        return r;
    endfunction

    // Every byte must carry an odd number of ones.
    function automatic logic parity_ok(input logic [0:63] k);
        return (^k[0:7])   & (^k[8:15])  & (^k[16:23]) & (^k[24:31]) &
               (^k[32:39]) & (^k[40:47]) & (^k[48:55]) & (^k[56:63]);
    endfunction

    // Key slot for a stage: 0 = K1, 1 = K2, 2 = K3.
    // Decrypt walks the bundle in reverse (K3, K2, K1).
    function automatic logic [1:0] key_sel(input logic [1:0] idx, input logic m, input logic e);
        logic [1:0] s;
        if (!m) begin
            s = 2'd0;
        end else begin
            case (idx)
                2'd0:    s = e ? 2'd0 : 2'd2;
                2'd1:    s = 2'd1;
                default: s = e ? 2'd2 : 2'd0;
            endcase
        end
        return s;
    endfunction

    // EDE: the middle stage runs opposite to the requested direction.
    function automatic logic stage_dir(input logic [1:0] idx, input logic m, input logic e);
        return (m && idx == 2'd1) ? !e : e;
    endfunction

    function automatic logic [0:55] pick(input logic [1:0] s, input logic [0:55] a,
                                         input logic [0:55] b, input logic [0:55] c);
        logic [0:55] r;
        case (s)
            2'd0:    r = a;
            2'd1:    r = b;
            default: r = c;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [0:55] k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic        mode_q, mode_d;
    logic        enc_q, enc_d;
    logic        load_ready_q, load_ready_d;
    logic [0:55] stage_key_q, stage_key_d;
    logic        stage_is_encrypt_q, stage_is_encrypt_d;
    logic [1:0]  stage_index_q, stage_index_d;
    logic        stage_valid_q, stage_valid_d;
    logic        seq_done_q, seq_done_d;
    logic        parity_err_q, parity_err_d;

    logic [0:55] pc1_in1, pc1_in2, pc1_in3;
    logic [1:0]  next_index;
    logic        last_stage;

    always_comb begin
        pc1_in1 = pc1(key_in[0:63]);
        pc1_in2 = pc1(key_in[64:127]);
        pc1_in3 = pc1(key_in[128:191]);
    end

    always_comb begin
        state_d            = state_q;
        k1_d               = k1_q;
        k2_d               = k2_q;
        k3_d               = k3_q;
        mode_d             = mode_q;
        enc_d              = enc_q;
        load_ready_d       = load_ready_q;
        stage_key_d        = stage_key_q;
        stage_is_encrypt_d = stage_is_encrypt_q;
        stage_index_d      = stage_index_q;
        stage_valid_d      = stage_valid_q;
        seq_done_d         = 1'b0;
        parity_err_d       = parity_err_q;
        next_index         = stage_index_q + 2'd1;
        last_stage         = mode_q ? (stage_index_q == 2'd2) : 1'b1;

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d            = ACTIVE;
                    k1_d               = pc1_in1;
                    k2_d               = pc1_in2;
                    k3_d               = pc1_in3;
                    mode_d             = mode_3des;
                    enc_d              = encrypt_in;
                    load_ready_d       = 1'b0;
                    stage_valid_d      = 1'b1;
                    stage_index_d      = 2'd0;
                    // Stage 0 comes straight from the input so it is
                    // presented the cycle after accept.
                    stage_key_d        = pick(key_sel(2'd0, mode_3des, encrypt_in),
                                              pc1_in1, pc1_in2, pc1_in3);
                    stage_is_encrypt_d = stage_dir(2'd0, mode_3des, encrypt_in);
                    parity_err_d       = mode_3des
                        ? !(parity_ok(key_in[0:63]) & parity_ok(key_in[64:127]) &
                            parity_ok(key_in[128:191]))
                        : !parity_ok(key_in[0:63]);
                end
            end
            ACTIVE: begin
                if (stage_done) begin
                    if (last_stage) begin
                        state_d            = IDLE;
                        load_ready_d       = 1'b1;
                        stage_valid_d      = 1'b0;
                        seq_done_d         = 1'b1;
                        stage_key_d        = '0;
                        stage_is_encrypt_d = 1'b0;
                        stage_index_d      = 2'd0;
                    end else begin
                        stage_index_d      = next_index;
                        stage_key_d        = pick(key_sel(next_index, mode_q, enc_q),
                                                  k1_q, k2_q, k3_q);
                        stage_is_encrypt_d = stage_dir(next_index, mode_q, enc_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            k1_q               <= '0;
            k2_q               <= '0;
            k3_q               <= '0;
            mode_q             <= 1'b0;
            enc_q              <= 1'b0;
            load_ready_q       <= 1'b1;
            stage_key_q        <= '0;
            stage_is_encrypt_q <= 1'b0;
            stage_index_q      <= 2'd0;
            stage_valid_q      <= 1'b0;
            seq_done_q         <= 1'b0;
            parity_err_q       <= 1'b0;
        end else begin
            state_q            <= state_d;
            k1_q               <= k1_d;
            k2_q               <= k2_d;
            k3_q               <= k3_d;
            mode_q             <= mode_d;
            enc_q              <= enc_d;
            load_ready_q       <= load_ready_d;
            stage_key_q        <= stage_key_d;
            stage_is_encrypt_q <= stage_is_encrypt_d;
            stage_index_q      <= stage_index_d;
            stage_valid_q      <= stage_valid_d;
            seq_done_q         <= seq_done_d;
            parity_err_q       <= parity_err_d;
        end
    end

    assign load_ready       = load_ready_q;
    assign stage_key        = stage_key_q;
    assign stage_is_encrypt = stage_is_encrypt_q;
    assign stage_index      = stage_index_q;
    assign stage_valid      = stage_valid_q;
    assign seq_done         = seq_done_q;
    assign parity_err       = parity_err_q;

endmodule

// File: tb/tb_des_key_sequencer.sv
// Testbench for des_key_sequencer: table of key bundles with expected
// per-stage PC-1 keys and directions (scoreboard queue), plus hand-written
// sequences for handshake corners, parity and mid-sequence reset.
module tb_des_key_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:191] key_in;
    logic         mode_3des;
    logic         encrypt_in;
    logic         load_valid;
    logic         load_ready;
    logic [0:55]  stage_key;
    logic         stage_is_encrypt;
    logic [1:0]   stage_index;
    logic         stage_valid;
    logic         stage_done;
    logic         seq_done;
    logic         parity_err;

    des_key_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .key_in           (key_in),
        .mode_3des        (mode_3des),
        .encrypt_in       (encrypt_in),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .stage_key        (stage_key),
        .stage_is_encrypt (stage_is_encrypt),
        .stage_index      (stage_index),
        .stage_valid      (stage_valid),
        .stage_done       (stage_done),
        .seq_done         (seq_done),
        .parity_err       (parity_err)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] K_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] K_01 = 64'h0101010101010101;
    localparam logic [63:0] K_FE = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] K_00 = 64'h0000000000000000;
    localparam logic [55:0] P_A  = 56'hF0CCAAF556678F;
    localparam logic [55:0] P_0  = 56'h00000000000000;
    localparam logic [55:0] P_F  = 56'hFFFFFFFFFFFFFF;

    typedef struct {
        logic [63:0]       k1, k2, k3;
        logic              mode;
        logic              enc;
        logic [2:0][55:0]  exp_key;
        logic [2:0]        exp_dir;
        logic              exp_par;
    } vec_t;

    typedef struct {
        logic [55:0] key;
        logic        dir;
        logic [1:0]  idx;
    } exp_t;

    vec_t vecs [6];
    exp_t sb [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] k1, input logic [63:0] k2, input logic [63:0] k3,
                                input logic m, input logic e,
                                input logic [55:0] x0, input logic d0,
                                input logic [55:0] x1, input logic d1,
                                input logic [55:0] x2, input logic d2,
                                input logic par);
        vec_t v;
        v.k1 = k1; v.k2 = k2; v.k3 = k3;
        v.mode = m; v.enc = e;
        v.exp_key[0] = x0; v.exp_key[1] = x1; v.exp_key[2] = x2;
        v.exp_dir[0] = d0; v.exp_dir[1] = d1; v.exp_dir[2] = d2;
        v.exp_par = par;
        return v;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_load_ready"},  load_ready,       1);
        check({tag, "_stage_valid"}, stage_valid,      0);
        check({tag, "_stage_key"},   stage_key,        0);
        check({tag, "_stage_enc"},   stage_is_encrypt, 0);
        check({tag, "_stage_index"}, stage_index,      0);
        check({tag, "_seq_done"},    seq_done,         0);
        check({tag, "_parity_err"},  parity_err,       0);
    endtask

    // Entered and left on a negedge with the DUT idle; stage_done is pulsed
    // every cycle, so the stages run back to back.
    task automatic run_vec(input vec_t v, input int tag);
        int   n;
        exp_t e;
        n = v.mode ? 3 : 1;
        check($sformatf("v%0d_ready_before", tag), load_ready, 1);
        key_in     = {v.k1, v.k2, v.k3};
        mode_3des  = v.mode;
        encrypt_in = v.enc;
        load_valid = 1'b1;
        for (int s = 0; s < n; s++) begin
            e.key = v.exp_key[s];
            e.dir = v.exp_dir[s];
            e.idx = 2'(s);
            sb.push_back(e);
        end
        @(negedge clk);
        load_valid = 1'b0;
        key_in     = '0;
        for (int s = 0; s < n; s++) begin
            check($sformatf("v%0d_s%0d_valid", tag, s), stage_valid, 1);
            check($sformatf("v%0d_s%0d_ready", tag, s), load_ready, 0);
            check($sformatf("v%0d_s%0d_parity", tag, s), parity_err, v.exp_par);
            if (sb.size() == 0) begin
                check($sformatf("v%0d_s%0d_sb_empty", tag, s), 1, 0);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d_s%0d_key", tag, s), stage_key, e.key);
                check($sformatf("v%0d_s%0d_dir", tag, s), stage_is_encrypt, e.dir);
                check($sformatf("v%0d_s%0d_index", tag, s), stage_index, e.idx);
            end
            stage_done = 1'b1;
            @(negedge clk);
            stage_done = 1'b0;
        end
        check($sformatf("v%0d_seq_done", tag), seq_done, 1);
        check($sformatf("v%0d_end_valid", tag), stage_valid, 0);
        check($sformatf("v%0d_end_ready", tag), load_ready, 1);
        check($sformatf("v%0d_end_key", tag), stage_key, 0);
        check($sformatf("v%0d_end_parity", tag), parity_err, v.exp_par);
        @(negedge clk);
        check($sformatf("v%0d_seq_done_drop", tag), seq_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = mk(K_A, K_00, K_00, 1'b0, 1'b1, P_A, 1'b1, P_0, 1'b0, P_0, 1'b0, 1'b0);
        vecs[1] = mk(K_A, K_01, K_FE, 1'b1, 1'b1, P_A, 1'b1, P_0, 1'b0, P_F, 1'b1, 1'b0);
        vecs[2] = mk(K_A, K_01, K_FE, 1'b1, 1'b0, P_F, 1'b0, P_0, 1'b1, P_A, 1'b0, 1'b0);
        vecs[3] = mk(K_A, K_00, K_FE, 1'b1, 1'b1, P_A, 1'b1, P_0, 1'b0, P_F, 1'b1, 1'b1);
        vecs[4] = mk(K_A, K_01, K_FE, 1'b0, 1'b0, P_A, 1'b0, P_0, 1'b0, P_0, 1'b0, 1'b0);
        vecs[5] = mk(K_A, K_00, K_FE, 1'b1, 1'b0, P_F, 1'b0, P_0, 1'b1, P_A, 1'b0, 1'b1);

        rst        = 1'b1;
        key_in     = '0;
        mode_3des  = 1'b0;
        encrypt_in = 1'b0;
        load_valid = 1'b0;
        stage_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        // stage_done while idle is ignored
        stage_done = 1'b1;
        @(negedge clk);
        stage_done = 1'b0;
        check("idle_done_valid", stage_valid, 0);
        check("idle_done_ready", load_ready, 1);
        check("idle_done_seq", seq_done, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // load_valid held through ACTIVE with a different bundle: ignored,
        // outputs stable while stage_done stays low, then accepted in the
        // seq_done cycle.
        key_in     = {K_A, K_01, K_FE};
        mode_3des  = 1'b1;
        encrypt_in = 1'b1;
        load_valid = 1'b1;
        @(negedge clk);
        key_in     = {K_FE, K_00, K_00};
        mode_3des  = 1'b0;
        encrypt_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("hold_c%0d_ready", c), load_ready, 0);
            check($sformatf("hold_c%0d_key", c), stage_key, P_A);
            check($sformatf("hold_c%0d_index", c), stage_index, 0);
            @(negedge clk);
        end
        stage_done = 1'b1;
        @(negedge clk);
        check("hold_s1_key", stage_key, P_0);
        check("hold_s1_dir", stage_is_encrypt, 0);
        check("hold_s1_index", stage_index, 1);
        @(negedge clk);
        check("hold_s2_key", stage_key, P_F);
        check("hold_s2_index", stage_index, 2);
        @(negedge clk);
        stage_done = 1'b0;
        check("hold_seq_done", seq_done, 1);
        check("hold_ready_in_done", load_ready, 1);
        check("hold_valid_in_done", stage_valid, 0);
        @(negedge clk);
        load_valid = 1'b0;
        check("reload_valid", stage_valid, 1);
        check("reload_key", stage_key, P_F);
        check("reload_dir", stage_is_encrypt, 1);
        check("reload_index", stage_index, 0);
        check("reload_parity", parity_err, 0);
        stage_done = 1'b1;
        @(negedge clk);
        stage_done = 1'b0;
        check("reload_seq_done", seq_done, 1);
        @(negedge clk);

        // reset at stage 1, coincident with stage_done and load_valid
        key_in     = {K_A, K_00, K_FE};
        mode_3des  = 1'b1;
        encrypt_in = 1'b1;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check("rstmid_parity_before", parity_err, 1);
        stage_done = 1'b1;
        @(negedge clk);
        stage_done = 1'b0;
        check("rstmid_index_before", stage_index, 1);
        rst        = 1'b1;
        stage_done = 1'b1;
        load_valid = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        stage_done = 1'b0;
        load_valid = 1'b0;
        check_reset_values("rstmid");
        run_vec(vecs[1], 6);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
